rr_req_client: RTL
==================

Name: rr_req_client

Overview:
- Requester-side companion to the 4-way round-robin arbiter. Its req output feeds the arbiter's req input, and the arbiter's registered gnt comes back in.
- Holds a per-client pending-job counter. Raises req[i] while client i has jobs not yet covered by a grant, and consumes one job per received grant.
- Reports each serviced job as a valid/id pulse.
- Flags protocol errors: a non-one-hot grant, or a grant to an idle client.

Parameters:
- CNT_W, 3, width of each per-client pending counter; maximum pending jobs = 2^CNT_W-1.
- TOT_W, 16, width of the total-serviced statistics counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- job_push  input  4  per-client job enqueue strobes; bit i adds one job to client i this cycle.
- req  output  4  request vector to arbiter; combinational from counters and gnt.
- gnt  input  4  grant vector from arbiter; at most one bit expected high.
- srv_valid  output  1  registered pulse: a job was serviced last cycle.
- srv_id  output  2  registered index of the serviced client; valid when srv_valid=1.
- pend_cnt  output  4*CNT_W  current pending count per client; client i occupies bits [i*CNT_W +: CNT_W].
- ovf  output  4  sticky per-client overflow flag: push attempted while the counter was at max.
- err_onehot  output  1  sticky flag: gnt had more than one bit set.
- err_idle  output  1  sticky flag: gnt[i]=1 while pend_cnt[i]=0.
- tot_srv  output  TOT_W  total jobs serviced; wraps modulo 2^TOT_W.
- clr_err  input  1  synchronous clear of ovf, err_onehot and err_idle.

Behaviour:
- Reset (asynchronous, rst=1): all counters=0, srv_valid=0, srv_id=0, ovf=0, err_onehot=0, err_idle=0, tot_srv=0. req therefore reads 0 during reset.
- Valid grant definition: g[i] = gnt[i] & (pend_cnt[i]!=0) & (gnt is one-hot).
- Request equation: req[i] = (pend_cnt[i] - g[i]) != 0.
  - This is the look-ahead term. The arbiter's grant lags req by one cycle, so without it the last job could draw a second grant.
  - With count=1 and an incoming grant, req[i] drops in the same cycle. No spurious grant follows.
- Counter update each rising edge: pend_cnt[i] <= pend_cnt[i] + job_push[i] - g[i].
  - Push and grant in the same cycle leave the count unchanged.
  - A push at max with no g[i] holds the count at max and sets ovf[i].
  - A push at max with g[i] in the same cycle is legal: the count stays at max and ovf is not set.
- Service outputs:
  - When any g[i]=1: next cycle srv_valid=1, srv_id=i, tot_srv increments by 1.
  - Otherwise srv_valid=0 and srv_id holds its last value.
- Invalid grants:
  - gnt with popcount>1: no counter changes, err_onehot set, no srv_valid.
  - gnt[i]=1 with pend_cnt[i]=0: ignored, err_idle set, no srv_valid.
  - gnt=0 is legal idle.
- clr_err=1 clears the sticky flags on the next edge. If a new error event occurs in the same cycle, the set wins over the clear.
- Reset mid-operation: pending jobs are discarded and req falls immediately. The arbiter is expected to be reset together with this block.
- Latency:
  - job_push to req high: 1 cycle, through the counter register.
  - req to gnt: 1 cycle, inside the arbiter.
  - gnt to srv_valid: 1 cycle.
- No state machine beyond the counters. Each client's req is the full request state.

Test Plan:
- Single job: push client 2 once, loopback through arbiter → req=0100 for 1 cycle, gnt=0100 next cycle, req drops the same cycle, srv_valid=1 with srv_id=2 one cycle later, pend_cnt[2]=0, err_idle=0.
- Fairness: push 3 jobs to each of clients 0..3 at once, looped through arbiter → 12 srv pulses, srv_id sequence 0,1,2,3 repeated 3 times, tot_srv=12, no errors.
- Concurrent push/grant: client 1 at count 2, push and grant in the same cycle → count stays 2, srv_valid=1 with srv_id=1 next cycle.
- Overflow: CNT_W=3, push client 0 eight times with no grants → pend_cnt[0]=7, ovf=0001. Assert clr_err → ovf=0000.
- Bad grants from a driven gnt (no arbiter): gnt=0110 → err_onehot=1, counts unchanged. gnt=1000 with pend_cnt[3]=0 → err_idle=1, srv_valid stays 0.
- Reset mid-stream: assert rst while clients hold counts 3,1,0,2 → req=0000 immediately, all counts=0, tot_srv=0, srv_valid=0.

Source files
------------

// File: rtl/rr_req_client.sv
// rtl/rr_req_client.sv - requester-side pending-job counters feeding a 4-way round-robin arbiter
// Tracks per-client jobs, derives look-ahead requests and reports serviced jobs and grant protocol errors.
module rr_req_client #(
    parameter int CNT_W = 3,
    parameter int TOT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         job_push,
    output logic [3:0]         req,
    input  logic [3:0]         gnt,
    output logic               srv_valid,
    output logic [1:0]         srv_id,
    output logic [4*CNT_W-1:0] pend_cnt,
    output logic [3:0]         ovf,
    output logic               err_onehot,
    output logic               err_idle,
    output logic [TOT_W-1:0]   tot_srv,
    input  logic               clr_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                  srv_valid_q, srv_valid_d;
    logic [1:0]            srv_id_q, srv_id_d;
    logic [3:0]            ovf_q, ovf_d;
    logic                  err_onehot_q, err_onehot_d;
    logic                  err_idle_q, err_idle_d;
    logic [TOT_W-1:0]      tot_q, tot_d;

    logic                  gnt_multi;
    logic                  gnt_one;
    logic [3:0]            g;
    logic [3:0]            ovf_evt;
    logic                  idle_evt;
    logic [CNT_W-1:0]      after_gnt;

    always_comb begin
        gnt_multi   = (gnt & (gnt - 4'd1)) != 4'd0;
        gnt_one     = (gnt != 4'd0) && !gnt_multi;
        g           = '0;
        ovf_evt     = '0;
        idle_evt    = 1'b0;
        req         = '0;
        cnt_d       = cnt_q;
        srv_valid_d = 1'b0;
        srv_id_d    = srv_id_q;
        after_gnt   = '0;

        for (int i = 0; i < 4; i++) begin
            g[i] = gnt[i] && (cnt_q[i] != '0) && gnt_one;
            if (gnt[i] && (cnt_q[i] == '0)) begin
                idle_evt = 1'b1;
            end

            // Subtracting the in-flight grant keeps the last job from drawing a second grant
            after_gnt = cnt_q[i] - {{(CNT_W-1){1'b0}}, g[i]};
            req[i]    = after_gnt != '0;

            if (job_push[i] && !g[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_evt[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else if (!job_push[i] && g[i]) begin
                cnt_d[i] = after_gnt;
            end

            if (g[i]) begin
                srv_valid_d = 1'b1;
                srv_id_d    = 2'(i);
            end
        end

        tot_d        = tot_q + {{(TOT_W-1){1'b0}}, srv_valid_d};
        ovf_d        = (clr_err ? 4'd0 : ovf_q) | ovf_evt;
        err_onehot_d = (clr_err ? 1'b0 : err_onehot_q) | gnt_multi;
        err_idle_d   = (clr_err ? 1'b0 : err_idle_q) | idle_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            srv_valid_q  <= 1'b0;
            srv_id_q     <= 2'd0;
            ovf_q        <= 4'd0;
            err_onehot_q <= 1'b0;
            err_idle_q   <= 1'b0;
            tot_q        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            srv_valid_q  <= srv_valid_d;
            srv_id_q     <= srv_id_d;
            ovf_q        <= ovf_d;
            err_onehot_q <= err_onehot_d;
            err_idle_q   <= err_idle_d;
            tot_q        <= tot_d;
        end
    end

    assign pend_cnt   = cnt_q;
    assign srv_valid  = srv_valid_q;
    assign srv_id     = srv_id_q;
    assign ovf        = ovf_q;
    assign err_onehot = err_onehot_q;
    assign err_idle   = err_idle_q;
    assign tot_srv    = tot_q;

endmodule
